// File: rtl/unary_pkg.sv
// unary_pkg: shared types, default sizing and target helper for the unary multiplier scheduler
package unary_pkg;
    localparam int DEF_INPUT_WIDTH = 32;
    localparam int DEF_COUNT_WIDTH = $clog2(DEF_INPUT_WIDTH + 1);
    typedef logic [DEF_COUNT_WIDTH-1:0] count_t;
    typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, TAIL} sched_state_t;
    function automatic int unary_target(input int a, input int b, input int w = DEF_INPUT_WIDTH, input int cw = DEF_COUNT_WIDTH);
        int p;
        p = (a * b) >> (cw - 1);
        return p > w ? w : p;
    endfunction
endpackage

// File: rtl/unary_mult_scheduler_stream_gen.sv
// unary_stream_gen: one operand's unary bit generator; thermometer order, or evenly spread with UNARY_SCHED_BRESENHAM_EN
// Ports: clear restarts the stream, advance steps to the next bit, value is the ones count, bit_o is the current bit.
module unary_stream_gen #(
    parameter int INPUT_WIDTH = 32,
    parameter int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   advance,
    input  logic [COUNT_WIDTH-1:0] value,
    output logic                   bit_o
);
`ifdef UNARY_SCHED_BRESENHAM_EN
    localparam logic [COUNT_WIDTH:0] W_S = (COUNT_WIDTH + 1)'(INPUT_WIDTH);
    logic [COUNT_WIDTH-1:0] acc_q, acc_d;
    logic [COUNT_WIDTH:0] sum;
    always_comb begin
        sum = {1'b0, acc_q} + {1'b0, value};
        bit_o = sum >= W_S;
        acc_d = clear ? '0 : advance ? COUNT_WIDTH'(bit_o ? sum - W_S : sum) : acc_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) acc_q <= '0;
        else acc_q <= acc_d;
    end
`else
    localparam logic [COUNT_WIDTH-1:0] W_C = COUNT_WIDTH'(INPUT_WIDTH);
    logic [COUNT_WIDTH-1:0] idx_q, idx_d;
    always_comb begin
        bit_o = idx_q < value;
        // the index parks at the stream length once the stream is exhausted
        idx_d = clear ? '0 : advance && idx_q != W_C ? idx_q + COUNT_WIDTH'(1) : idx_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) idx_q <= '0;
        else idx_q <= idx_d;
    end
`endif
endmodule

// File: rtl/unary_mult_scheduler.sv
// unary_mult_scheduler: feeds one unary multiplier per job and completes its INPUT_WIDTH-beat result stream
// Build option: UNARY_SCHED_BRESENHAM_EN selects evenly spread operand streams instead of thermometer order.
// Ports: job_valid/job_ready/job_a/job_b take a job; m_a/m_b/m_ready/m_rst_n/m_valid/m_y drive the multiplier;
//        out_valid/out_ready/out_y/out_last carry the backpressured result stream.
module unary_mult_scheduler
    import unary_pkg::*;
#(
    parameter int INPUT_WIDTH = DEF_INPUT_WIDTH,
    parameter int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   job_valid,
    output logic                   job_ready,
    input  logic [COUNT_WIDTH-1:0] job_a,
    input  logic [COUNT_WIDTH-1:0] job_b,
    output logic                   m_a,
    output logic                   m_b,
    output logic [1:0]             m_ready,
    output logic                   m_rst_n,
    input  logic                   m_valid,
    input  logic                   m_y,
    output logic                   out_valid,
    output logic                   out_y,
    input  logic                   out_ready,
    output logic                   out_last
);
    localparam logic [COUNT_WIDTH-1:0] W_C = COUNT_WIDTH'(INPUT_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] W_M1 = COUNT_WIDTH'(INPUT_WIDTH - 1);
    sched_state_t state_q, state_d;
    logic [COUNT_WIDTH-1:0] a_q, a_d, b_q, b_d, target_q, target_d, ca, cb;
    logic [COUNT_WIDTH-1:0] feed_cnt_q, feed_cnt_d, out_cnt_q, out_cnt_d, ones_q, ones_d;
    logic job_ready_q, job_ready_d, m_a_q, m_a_d, m_b_q, m_b_d, m_rst_n_q, m_rst_n_d, fresh_q, fresh_d;
    logic ov_q, ov_d, oy_q, oy_d, ol_q, ol_d, hv_q, hv_d, hy_q, hy_d, hl_q, hl_d;
    logic accept, free, load, cap, tail_beat, nb, nb_y, nb_l, to_skid, gen_a, gen_b;
    unary_stream_gen #(.INPUT_WIDTH(INPUT_WIDTH), .COUNT_WIDTH(COUNT_WIDTH)) u_gen_a (
        .clk(clk), .reset(reset), .clear(accept), .advance(load), .value(a_q), .bit_o(gen_a)
    );
    unary_stream_gen #(.INPUT_WIDTH(INPUT_WIDTH), .COUNT_WIDTH(COUNT_WIDTH)) u_gen_b (
        .clk(clk), .reset(reset), .clear(accept), .advance(load), .value(b_q), .bit_o(gen_b)
    );
    always_comb begin
        accept = state_q == IDLE && job_ready_q && job_valid;
        ca = job_a > W_C ? W_C : job_a;
        cb = job_b > W_C ? W_C : job_b;
        free = !ov_q || out_ready;
        // the generators step once in CLEAR to preload bit 0, then once per advance
        load = state_q == CLEAR || (state_q == FEED && free);
        cap = fresh_q && m_valid && out_cnt_q < W_C && (state_q == FEED || state_q == FLUSH);
        tail_beat = state_q == TAIL && !hv_q && free && out_cnt_q < W_C;
        nb = cap || tail_beat;
        nb_y = cap ? m_y : ones_q < target_q;
        nb_l = out_cnt_q == W_M1;
        // a captured beat that cannot enter the output register (busy, or behind an older skid beat) waits in the skid slot
        to_skid = nb && (!free || hv_q);
        state_d = accept ? CLEAR
                : state_q == CLEAR ? FEED
                : state_q == FEED && free && feed_cnt_q == W_M1 ? FLUSH
                : state_q == FLUSH ? TAIL
                : state_q == TAIL && out_cnt_q == W_C && !hv_q && free ? IDLE
                : state_q;
        a_d = accept ? ca : a_q;
        b_d = accept ? cb : b_q;
        target_d = accept ? COUNT_WIDTH'(unary_target(int'(ca), int'(cb), INPUT_WIDTH, COUNT_WIDTH)) : target_q;
        feed_cnt_d = accept ? '0 : state_q == FEED && free ? feed_cnt_q + COUNT_WIDTH'(1) : feed_cnt_q;
        out_cnt_d = accept ? '0 : nb ? out_cnt_q + COUNT_WIDTH'(1) : out_cnt_q;
        ones_d = accept ? '0 : nb && nb_y && ones_q < target_q ? ones_q + COUNT_WIDTH'(1) : ones_q;
        fresh_d = state_q == FEED && free;
        job_ready_d = state_d == IDLE;
        m_rst_n_d = state_d != CLEAR;
        m_a_d = state_d == FEED ? (load ? gen_a : m_a_q) : 1'b0;
        m_b_d = state_d == FEED ? (load ? gen_b : m_b_q) : 1'b0;
        ov_d = free ? hv_q || nb : ov_q;
        oy_d = free ? (hv_q ? hy_q : nb && nb_y) : oy_q;
        ol_d = free ? (hv_q ? hl_q : nb && nb_l) : ol_q;
        hv_d = free ? hv_q && nb : hv_q || nb;
        hy_d = to_skid ? nb_y : hy_q;
        hl_d = to_skid ? nb_l : hl_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q <= '0;
            b_q <= '0;
            target_q <= '0;
            feed_cnt_q <= '0;
            out_cnt_q <= '0;
            ones_q <= '0;
            fresh_q <= 1'b0;
            job_ready_q <= 1'b0;
            m_rst_n_q <= 1'b0;
            m_a_q <= 1'b0;
            m_b_q <= 1'b0;
            ov_q <= 1'b0;
            oy_q <= 1'b0;
            ol_q <= 1'b0;
            hv_q <= 1'b0;
            hy_q <= 1'b0;
            hl_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            target_q <= target_d;
            feed_cnt_q <= feed_cnt_d;
            out_cnt_q <= out_cnt_d;
            ones_q <= ones_d;
            fresh_q <= fresh_d;
            job_ready_q <= job_ready_d;
            m_rst_n_q <= m_rst_n_d;
            m_a_q <= m_a_d;
            m_b_q <= m_b_d;
            ov_q <= ov_d;
            oy_q <= oy_d;
            ol_q <= ol_d;
            hv_q <= hv_d;
            hy_q <= hy_d;
            hl_q <= hl_d;
        end
    end
    assign job_ready = job_ready_q;
    assign m_a = m_a_q;
    assign m_b = m_b_q;
    assign m_ready = {2{state_q == FEED && free}};
    assign m_rst_n = m_rst_n_q;
    assign out_valid = ov_q;
    assign out_y = oy_q;
    assign out_last = ol_q;
endmodule

// File: tb/tb_unary_mult_scheduler.sv
// tb_unary_mult_scheduler: randomized bench with a behavioural multiplier and result-stream reference
module tb_unary_mult_scheduler;
    localparam int W = 32;
    localparam int CW = $clog2(W + 1);
    logic clk = 0, reset = 1, job_valid = 0, out_ready = 0, m_valid = 0, m_y = 0;
    logic [CW-1:0] job_a = '0, job_b = '0;
    logic job_ready, m_a, m_b, m_rst_n, out_valid, out_y, out_last;
    logic [1:0] m_ready;
    int tests = 0, fails = 0;
    int ca = 0, cb = 0, em = 0, beats = 0, ones = 0, tgt = 0, exp_a = 0, exp_b = 0, rmode = 0;
    bit pend = 0;
    always #5 clk = ~clk;
    unary_mult_scheduler #(.INPUT_WIDTH(W), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
        .job_a(job_a), .job_b(job_b), .m_a(m_a), .m_b(m_b), .m_ready(m_ready),
        .m_rst_n(m_rst_n), .m_valid(m_valid), .m_y(m_y), .out_valid(out_valid),
        .out_y(out_y), .out_ready(out_ready), .out_last(out_last)
    );
    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? !out_ready : 1'($urandom_range(1));
    end
    // multiplier stand-in: emits a 1 only once the ones seen so far guarantee it
    initial forever begin
        @(negedge clk);
        if (!m_rst_n) begin
            ca = 0;
            cb = 0;
            em = 0;
            pend = 0;
        end else begin
            pend = m_ready == 2'b11;
            if (pend) begin
                ca += int'(m_a);
                cb += int'(m_b);
            end
        end
        if (out_valid && !out_ready) check("stall_m_ready", int'(m_ready), 0);
        @(posedge clk);
        #1;
        m_valid = pend && em < ca * cb / (1 << (CW - 1)) && $urandom_range(3) != 0;
        m_y = m_valid;
        em += int'(m_valid);
    end
    // result stream must be target ones then zeros, last flag on beat W
    initial forever begin
        @(negedge clk);
        if (out_valid && out_ready) begin
            check("beat_y", int'(out_y), int'(beats < tgt));
            check("beat_last", int'(out_last), int'(beats == W - 1));
            ones += int'(out_y);
            beats++;
        end
    end
    task automatic reset_checks(input string tag);
        check({tag, "_job_ready"}, int'(job_ready), 0);
        check({tag, "_m_a"}, int'(m_a), 0);
        check({tag, "_m_b"}, int'(m_b), 0);
        check({tag, "_m_ready"}, int'(m_ready), 0);
        check({tag, "_m_rst_n"}, int'(m_rst_n), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_y"}, int'(out_y), 0);
        check({tag, "_out_last"}, int'(out_last), 0);
    endtask
    task automatic start_job(input int a, input int b, input int mode);
        int cyc;
        exp_a = a > W ? W : a;
        exp_b = b > W ? W : b;
        tgt = exp_a * exp_b / (1 << (CW - 1));
        if (tgt > W) tgt = W;
        cyc = 0;
        while (!job_ready && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("job_ready_idle", int'(job_ready), 1);
        rmode = mode;
        beats = 0;
        ones = 0;
        job_a = CW'(a);
        job_b = CW'(b);
        job_valid = 1;
        @(posedge clk);
        #1;
        job_valid = 0;
        check("job_ready_busy", int'(job_ready), 0);
    endtask
    task automatic finish_job(input string tag);
        int cyc, rl;
        bit done;
        cyc = 0;
        rl = 0;
        done = 0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            rl += int'(!m_rst_n);
            done = out_valid && out_ready && out_last;
            cyc++;
        end
        check({tag, "_done"}, int'(done), 1);
        @(posedge clk);
        #1;
        check({tag, "_beats"}, beats, W);
        check({tag, "_ones"}, ones, tgt);
        check({tag, "_clear_cycles"}, rl, 1);
        check({tag, "_a_ones"}, ca, exp_a);
        check({tag, "_b_ones"}, cb, exp_b);
        check({tag, "_back_idle"}, int'(job_ready), 1);
    endtask
    task automatic run_job(input int a, input int b, input int mode, input string tag);
        start_job(a, b, mode);
        finish_job(tag);
    endtask
    initial begin
        int n, cyc;
        repeat (3) @(negedge clk);
        reset_checks("reset");
        @(posedge clk);
        #1;
        reset = 0;
        run_job(32, 32, 0, "full");
        run_job(0, 20, 0, "zero_a");
        run_job(16, 16, 0, "half");
        run_job(24, 8, 1, "toggle");
        start_job(20, 20, 0);
        n = 0;
        cyc = 0;
        while (n < 10 && cyc < 500) begin
            @(negedge clk);
            n += int'(m_ready == 2'b11);
            cyc++;
        end
        check("pre_reset_feed", n, 10);
        @(posedge clk);
        #1;
        reset = 1;
        @(negedge clk);
        reset_checks("mid_reset");
        @(posedge clk);
        #1;
        reset = 0;
        repeat (4) begin
            @(negedge clk);
            check("post_reset_out_valid", int'(out_valid), 0);
        end
        run_job(8, 8, 0, "after_reset");
        run_job(40, 40, 0, "clamp");
        run_job(16, 8, 2, "back_to_back");
        for (int i = 0; i < 6; i++) run_job(int'($urandom_range(40)), int'($urandom_range(40)), int'($urandom_range(2)), "random");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
